// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants and types for the shared binary-to-BCD engine.
//   BCD_WIDTH / BCD_DIGITS : default operand width and BCD digit count
//   bcd_state_e            : sequencer states (IDLE, SHIFT)
//   ADD3_THRESH / ADD3_CORR: double-dabble digit correction constants
//   id_width()             : requester index width, max(1, clog2(n))
package bcd_pkg;

   localparam int unsigned BCD_WIDTH  = 16;
   localparam int unsigned BCD_DIGITS = 5;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } bcd_state_e;

   localparam logic [3:0] ADD3_THRESH = 4'd4;
   localparam logic [3:0] ADD3_CORR   = 4'd3;

   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? 32'($clog2(n)) : 32'd1;
   endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// bcd_dabble_step: one combinational double-dabble iteration.
//   acc_i [4*DIGITS-1:0] : BCD accumulator before the step
//   opd_i [WIDTH-1:0]    : remaining binary operand before the step
//   acc_o [4*DIGITS-1:0] : accumulator after add-3 correction and shift
//   opd_o [WIDTH-1:0]    : operand after shift (MSB moved into accumulator)
module bcd_dabble_step
   import bcd_pkg::*;
#(
   parameter int unsigned WIDTH  = BCD_WIDTH,
   parameter int unsigned DIGITS = BCD_DIGITS
) (
   input  logic [4*DIGITS-1:0] acc_i,
   input  logic [WIDTH-1:0]    opd_i,
   output logic [4*DIGITS-1:0] acc_o,
   output logic [WIDTH-1:0]    opd_o
);

   logic [4*DIGITS-1:0] adj;

   // Per-digit add-3; digits are corrected independently, no carry between them.
   always_comb begin
      adj = acc_i;
      for (int unsigned d = 0; d < DIGITS; d++) begin
         if (acc_i[4*d +: 4] > ADD3_THRESH) begin
            adj[4*d +: 4] = acc_i[4*d +: 4] + ADD3_CORR;
         end
      end
   end

   // Shift the concatenation so the operand MSB enters digit 0.
   assign {acc_o, opd_o} = {adj, opd_i} << 1;

endmodule

// File: rtl/bcd_conv_sched.sv
// bcd_conv_sched: shared serial binary-to-BCD converter with round-robin
// arbitration between N requesters. One double-dabble iteration per clock.
//   clk, rst_n : clock, asynchronous active-low reset
//   req_i      : per-requester level request
//   bin_i      : operands, requester k in [k*WIDTH +: WIDTH]
//   gnt_o      : one-hot grant pulse on capture
//   busy_o     : conversion in progress
//   done_o     : result valid pulse
//   id_o       : requester index of the current result
//   bcd_o      : packed BCD result, digit 0 in [3:0]
//   blank_o    : leading-zero blank flags (only when BCD_BLANK_EN is defined)
module bcd_conv_sched
   import bcd_pkg::*;
#(
   parameter int unsigned N      = 2,
   parameter int unsigned WIDTH  = BCD_WIDTH,
   parameter int unsigned DIGITS = BCD_DIGITS
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N-1:0]            req_i,
   input  logic [N*WIDTH-1:0]      bin_i,
   output logic [N-1:0]            gnt_o,
   output logic                    busy_o,
   output logic                    done_o,
   output logic [id_width(N)-1:0]  id_o,
   output logic [4*DIGITS-1:0]     bcd_o
`ifdef BCD_BLANK_EN
   ,
   output logic [DIGITS-1:0]       blank_o
`endif
);

   localparam int unsigned IDW  = id_width(N);
   localparam int unsigned CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   bcd_state_e          state_q;
   logic [IDW-1:0]      last_q;
   logic [CNTW-1:0]     cnt_q;
   logic [4*DIGITS-1:0] acc_q;
   logic [WIDTH-1:0]    opd_q;
   logic [N-1:0]        gnt_q;
   logic                done_q;
   logic [IDW-1:0]      id_q;
   logic [4*DIGITS-1:0] bcd_q;

   logic [4*DIGITS-1:0] step_acc;
   logic [WIDTH-1:0]    step_opd;

   logic                any_req;
   logic [IDW-1:0]      pick;
   logic [WIDTH-1:0]    pick_bin;
   int unsigned         scan_idx;

   bcd_dabble_step #(
      .WIDTH  (WIDTH),
      .DIGITS (DIGITS)
   ) u_step (
      .acc_i (acc_q),
      .opd_i (opd_q),
      .acc_o (step_acc),
      .opd_o (step_opd)
   );

   // Round-robin search starting one past the last granted requester.
   always_comb begin
      any_req  = 1'b0;
      pick     = '0;
      pick_bin = '0;
      scan_idx = 0;
      for (int unsigned i = 1; i <= N; i++) begin
         scan_idx = (32'(last_q) + i) % N;
         if (!any_req && req_i[IDW'(scan_idx)]) begin
            any_req  = 1'b1;
            pick     = IDW'(scan_idx);
            pick_bin = bin_i[scan_idx*WIDTH +: WIDTH];
         end
      end
   end

`ifdef BCD_BLANK_EN
   logic [DIGITS-1:0] blank_c;
   logic [DIGITS-1:0] blank_q;
   logic              hi_zero;

   // Digit i blanks when it and every higher digit are zero; digit 0 never blanks.
   always_comb begin
      blank_c = '0;
      hi_zero = 1'b1;
      for (int d = int'(DIGITS) - 1; d >= 1; d--) begin
         hi_zero    = hi_zero && (step_acc[4*d +: 4] == 4'd0);
         blank_c[d] = hi_zero;
      end
   end

   assign blank_o = blank_q;
`else
   // No blank flags in this build.
`endif

   // Sequencer: capture in IDLE, WIDTH iterations in SHIFT, publish on the last.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         last_q  <= IDW'(N - 1);
         cnt_q   <= '0;
         acc_q   <= '0;
         opd_q   <= '0;
         gnt_q   <= '0;
         done_q  <= 1'b0;
         id_q    <= '0;
         bcd_q   <= '0;
`ifdef BCD_BLANK_EN
         blank_q <= '0;
`endif
      end else begin
         gnt_q  <= '0;
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (any_req) begin
                  opd_q   <= pick_bin;
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  last_q  <= pick;
                  gnt_q   <= {{(N-1){1'b0}}, 1'b1} << pick;
                  state_q <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               acc_q <= step_acc;
               opd_q <= step_opd;
               cnt_q <= cnt_q + CNTW'(1);
               if (cnt_q == CNTW'(WIDTH - 1)) begin
                  bcd_q   <= step_acc;
                  id_q    <= last_q;
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
`ifdef BCD_BLANK_EN
                  blank_q <= blank_c;
`endif
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign gnt_o  = gnt_q;
   assign busy_o = (state_q == ST_SHIFT);
   assign done_o = done_q;
   assign id_o   = id_q;
   assign bcd_o  = bcd_q;

endmodule

// File: tb/tb_bcd_conv_sched.sv
// tb_bcd_conv_sched: self-checking bench for bcd_conv_sched (N=2, WIDTH=16,
// DIGITS=5). A transaction-level model predicts every output each cycle;
// directed cases pin literal results. Blank checks are active when
// BCD_BLANK_EN is defined.
module tb_bcd_conv_sched;

   localparam int N      = 2;
   localparam int WIDTH  = 16;
   localparam int DIGITS = 5;

   logic               clk;
   logic               rst_n;
   logic [N-1:0]       req_i;
   logic [N*WIDTH-1:0] bin_i;
   logic [N-1:0]       gnt_o;
   logic               busy_o;
   logic               done_o;
   logic [0:0]         id_o;
   logic [19:0]        bcd_o;
`ifdef BCD_BLANK_EN
   logic [4:0]         blank_o;
`endif

   int total = 0;
   int bad   = 0;

   // Model state
   bit          m_idle;
   int          m_last;
   int          m_owner;
   int          m_edges;
   int unsigned m_val;
   logic [1:0]  m_gnt;
   bit          m_done;
   int          m_id;
   logic [19:0] m_bcd;
   logic [4:0]  m_blank;

   bcd_conv_sched #(.N(N), .WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .req_i  (req_i),
      .bin_i  (bin_i),
      .gnt_o  (gnt_o),
      .busy_o (busy_o),
      .done_o (done_o),
      .id_o   (id_o),
      .bcd_o  (bcd_o)
`ifdef BCD_BLANK_EN
      ,
      .blank_o(blank_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [19:0] to_bcd(input int unsigned v);
      logic [19:0] r;
      int unsigned p;
      r = '0;
      p = 1;
      for (int d = 0; d < DIGITS; d++) begin
         r[4*d +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   function automatic logic [4:0] blanks(input int unsigned v);
      logic [4:0] b;
      int unsigned p;
      b = '0;
      p = 10;
      for (int i = 1; i < DIGITS; i++) begin
         b[i] = (v < p);
         p = p * 10;
      end
      return b;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_idle  = 1'b1;
      m_last  = N - 1;
      m_owner = 0;
      m_edges = 0;
      m_val   = 0;
      m_gnt   = '0;
      m_done  = 1'b0;
      m_id    = 0;
      m_bcd   = '0;
      m_blank = '0;
   endtask

   // Transaction view of one clock edge using the inputs present at that edge.
   task automatic model_edge();
      bit found;
      m_gnt  = '0;
      m_done = 1'b0;
      if (m_idle) begin
         found = 1'b0;
         for (int s = 1; s <= N; s++) begin
            int k;
            k = (m_last + s) % N;
            if (!found && req_i[k]) begin
               found   = 1'b1;
               m_last  = k;
               m_owner = k;
               m_val   = 32'(bin_i[k*WIDTH +: WIDTH]);
               m_edges = 0;
               m_gnt   = 2'(1 << k);
               m_idle  = 1'b0;
            end
         end
      end else begin
         m_edges++;
         if (m_edges == WIDTH) begin
            m_done  = 1'b1;
            m_id    = m_owner;
            m_bcd   = to_bcd(m_val);
            m_blank = blanks(m_val);
            m_idle  = 1'b1;
         end
      end
   endtask

   task automatic check_outputs();
      chk("gnt", 32'(gnt_o), 32'(m_gnt));
      chk("gnt_onehot", 32'($onehot0(gnt_o)), 32'd1);
      chk("busy", 32'(busy_o), 32'(!m_idle));
      chk("done", 32'(done_o), 32'(m_done));
      chk("id", 32'(id_o), 32'(m_id));
      chk("bcd", 32'(bcd_o), 32'(m_bcd));
`ifdef BCD_BLANK_EN
      chk("blank", 32'(blank_o), 32'(m_blank));
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   // Single request on requester k; checks grant, 17-edge latency and result.
   task automatic run_one(input int k, input int unsigned v, input logic [19:0] exp_bcd,
                          input string name);
      int  edges;
      bit  seen;
      req_i    = '0;
      req_i[k] = 1'b1;
      bin_i[k*WIDTH +: WIDTH] = 16'(v);
      tick();
      edges = 1;
      chk({name, "_gnt"}, 32'(gnt_o), 32'(1 << k));
      req_i = '0;
      seen  = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         tick();
         edges++;
         if (done_o) seen = 1'b1;
      end
      chk({name, "_done_seen"}, 32'(seen), 32'd1);
      chk({name, "_edges"}, 32'(edges), 32'd17);
      chk({name, "_bcd"}, 32'(bcd_o), 32'(exp_bcd));
      chk({name, "_id"}, 32'(id_o), 32'(k));
   endtask

   function automatic logic [15:0] rand_opd();
      case ($urandom_range(7, 0))
         0:       return 16'd0;
         1:       return 16'd65535;
         2:       return 16'd9999;
         3:       return 16'd10000;
         default: return 16'($urandom_range(65535, 0));
      endcase
   endfunction

   initial begin
      int          ids[3];
      logic [19:0] vals[3];
      int          at[3];
      int          ndone;
      int          ngnt;
      int          cyc;
      int          late_done;

      rst_n = 1'b0;
      req_i = '0;
      bin_i = '0;
      model_reset();

      // Reset values
      #12;
      chk("rst_gnt", 32'(gnt_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_id", 32'(id_o), 32'd0);
      chk("rst_bcd", 32'(bcd_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Contention: both requesters held, order must start at 0 and alternate
      req_i = 2'b11;
      bin_i[0 +: WIDTH]     = 16'd123;
      bin_i[WIDTH +: WIDTH] = 16'd4567;
      ndone = 0;
      ngnt  = 0;
      cyc   = 0;
      while (ndone < 3 && cyc < 100) begin
         tick();
         cyc++;
         if (gnt_o != '0) ngnt++;
         if (done_o) begin
            ids[ndone]  = int'(id_o);
            vals[ndone] = bcd_o;
            at[ndone]   = cyc;
            ndone++;
         end
      end
      req_i = '0;
      chk("cont_ndone", 32'(ndone), 32'd3);
      if (ndone == 3) begin
         chk("cont_id0", 32'(ids[0]), 32'd0);
         chk("cont_bcd0", 32'(vals[0]), 32'h00123);
         chk("cont_id1", 32'(ids[1]), 32'd1);
         chk("cont_bcd1", 32'(vals[1]), 32'h04567);
         chk("cont_id2", 32'(ids[2]), 32'd0);
         chk("cont_bcd2", 32'(vals[2]), 32'h00123);
         chk("cont_gap01", 32'(at[1] - at[0]), 32'd17);
         chk("cont_gap12", 32'(at[2] - at[1]), 32'd17);
         chk("cont_ngnt", 32'(ngnt), 32'd3);
      end
      tick();

      // Directed boundary operands
      run_one(0, 0,     20'h00000, "zero");
      run_one(1, 65535, 20'h65535, "max");
      run_one(0, 9999,  20'h09999, "v9999");
      run_one(1, 10000, 20'h10000, "v10000");

      // Reset in the middle of a conversion (cnt = 8)
      req_i = 2'b01;
      bin_i[0 +: WIDTH] = 16'd12345;
      tick();
      chk("mid_gnt", 32'(gnt_o), 32'd1);
      req_i = '0;
      for (int c = 0; c < 8; c++) tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_gnt", 32'(gnt_o), 32'd0);
      chk("mid_rst_busy", 32'(busy_o), 32'd0);
      chk("mid_rst_done", 32'(done_o), 32'd0);
      chk("mid_rst_id", 32'(id_o), 32'd0);
      chk("mid_rst_bcd", 32'(bcd_o), 32'd0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      late_done = 0;
      for (int c = 0; c < 25; c++) begin
         tick();
         if (done_o) late_done++;
      end
      chk("mid_no_done", 32'(late_done), 32'd0);
      run_one(1, 42, 20'h00042, "after_rst");

`ifdef BCD_BLANK_EN
      run_one(0, 305, 20'h00305, "blank305");
      chk("blank305_flags", 32'(blank_o), 32'(5'b11000));
      run_one(0, 0, 20'h00000, "blank0");
      chk("blank0_flags", 32'(blank_o), 32'(5'b11110));
      run_one(1, 60000, 20'h60000, "blank60000");
      chk("blank60000_flags", 32'(blank_o), 32'(5'b00000));
`endif

      // Random sweep: requests with random gaps, model checks every cycle
      ndone = 0;
      cyc   = 0;
      while (ndone < 1000 && cyc < 60000) begin
         tick();
         cyc++;
         if (done_o) ndone++;
         for (int k = 0; k < N; k++) begin
            if (req_i[k]) begin
               if (gnt_o[k]) begin
                  if ($urandom_range(1, 0) == 0) req_i[k] = 1'b0;
                  else bin_i[k*WIDTH +: WIDTH] = rand_opd();
               end
            end else if ($urandom_range(3, 0) == 0) begin
               req_i[k] = 1'b1;
               bin_i[k*WIDTH +: WIDTH] = rand_opd();
            end
         end
      end
      chk("sweep_count", 32'(ndone >= 1000), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
